// File: rtl/pio_fifo_pj.sv
// ============================================================================
// Module   : pio_fifo_pj
// Purpose  : First-word-fall-through FIFO for the PIO TX/RX data paths.
//            The join mode doubles capacity. Define FIFO_ERR_EN to add the
//            sticky overflow/underflow flags and err_clr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pio_fifo_pj #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(2*DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fjoin,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pull,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [LW-1:0]    level,
   input  logic [LW-1:0]    thresh,
`ifdef FIFO_ERR_EN
   input  logic             err_clr,
   output logic             overflow,
   output logic             underflow,
`endif
   output logic             below
);

   localparam logic [LW-1:0] c_cap_n   = LW'(DEPTH);
   localparam logic [LW-1:0] c_cap_j   = LW'(2*DEPTH);
   localparam logic [LW-1:0] c_lvl_one = LW'(1);
   localparam logic [LW-2:0] c_ptr_one = (LW-1)'(1);

   logic [WIDTH-1:0] r_mem [0:2*DEPTH-1];
   logic [LW-2:0]    r_rd_ptr;
   logic [LW-2:0]    r_wr_ptr;
   logic [LW-1:0]    r_level;
   logic             r_join_q;

   logic [LW-1:0]    w_cap;
   logic [LW-1:0]    w_cap_m1;
   logic             w_flush;
   logic             w_push_ok;
   logic             w_pull_ok;
   logic [LW-2:0]    w_rd_nxt;
   logic [LW-2:0]    w_wr_nxt;

   assign w_cap    = r_join_q ? c_cap_j : c_cap_n;
   assign w_cap_m1 = w_cap - c_lvl_one;
   assign empty    = (r_level == '0);
   assign full     = (r_level == w_cap);
   assign level    = r_level;
   assign below    = (r_level < thresh);

   // A join change flushes the FIFO, so all traffic in that cycle is dropped.
   assign w_flush   = (fjoin != r_join_q);
   assign w_push_ok = push && !full  && !w_flush;
   assign w_pull_ok = pull && !empty && !w_flush;

   assign w_rd_nxt = (r_rd_ptr == w_cap_m1[LW-2:0]) ? '0 : r_rd_ptr + c_ptr_one;
   assign w_wr_nxt = (r_wr_ptr == w_cap_m1[LW-2:0]) ? '0 : r_wr_ptr + c_ptr_one;

   assign dout = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_join_q <= fjoin;
      end else if (w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_join_q <= fjoin;
      end else begin
         if (w_push_ok) r_wr_ptr <= w_wr_nxt;
         if (w_pull_ok) r_rd_ptr <= w_rd_nxt;
         if (w_push_ok && !w_pull_ok)
            r_level <= r_level + c_lvl_one;
         else if (w_pull_ok && !w_push_ok)
            r_level <= r_level - c_lvl_one;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= din;
   end

`ifdef FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // A new error event takes priority over err_clr in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (push && full)       r_overflow  <= 1'b1;
         else if (err_clr)       r_overflow  <= 1'b0;
         if (pull && empty)      r_underflow <= 1'b1;
         else if (err_clr)       r_underflow <= 1'b0;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pio_fifo_pj.sv
// ============================================================================
// Module   : tb_pio_fifo_pj
// Purpose  : Directed self-checking bench for pio_fifo_pj (WIDTH=32, DEPTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pio_fifo_pj;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(2*DEPTH+1);

   logic             clk = 1'b0;
   logic             reset;
   logic             fjoin;
   logic             push;
   logic [WIDTH-1:0] din;
   logic             pull;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic [LW-1:0]    level;
   logic [LW-1:0]    thresh;
   logic             below;
`ifdef FIFO_ERR_EN
   logic             err_clr;
   logic             overflow;
   logic             underflow;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pio_fifo_pj #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .fjoin(fjoin), .push(push), .din(din),
      .pull(pull), .dout(dout), .empty(empty), .full(full), .level(level),
      .thresh(thresh),
`ifdef FIFO_ERR_EN
      .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
      .below(below)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fjoin = 1'b0; push = 1'b0; pull = 1'b0; din = '0; thresh = 4'd2;
`ifdef FIFO_ERR_EN
      err_clr = 1'b0;
`endif
      tick(); tick();
      reset = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", full); end
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", level); end
      n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL rst_dout got %h exp 0", dout); end
      n_checks++; if (below !== 1'b1) begin n_fail++; $display("FAIL rst_below got %b exp 1", below); end
   endtask

   task automatic test_fill_drain();
      logic [LW-1:0] exp_lvl;
      for (int i = 0; i < 5; i++) begin
         push = 1'b1; din = 32'hA0 + i;
         tick();
         exp_lvl = (i < 4) ? LW'(i + 1) : 4'd4;
         n_checks++; if (level !== exp_lvl) begin n_fail++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, exp_lvl); end
      end
      push = 1'b0;
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (dout !== 32'hA0 + i) begin n_fail++; $display("FAIL drain_dout[%0d] got %h exp %h", i, dout, 32'hA0 + i); end
         pull = 1'b1; tick(); pull = 1'b0;
      end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty); end
      n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL drain_dout_empty got %h exp 0", dout); end
      pull = 1'b1; tick(); pull = 1'b0;
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL pull_empty_level got %0d exp 0", level); end
   endtask

   task automatic test_join_capacity();
      logic [WIDTH-1:0] q[$];
      logic [WIDTH-1:0] e;
      fjoin = 1'b1; tick();
      for (int i = 1; i <= 9; i++) begin
         push = 1'b1; din = WIDTH'(i); tick();
      end
      push = 1'b0;
      n_checks++; if (level !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL join_full level %0d full %b exp 8/1", level, full); end
      for (int i = 1; i <= 8; i++) begin
         n_checks++; if (dout !== WIDTH'(i)) begin n_fail++; $display("FAIL join_dout[%0d] got %h exp %h", i, dout, i); end
         pull = 1'b1; tick(); pull = 1'b0;
      end
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++) begin
            push = 1'b1; din = 32'h100 + 3*r + k; q.push_back(32'h100 + 3*r + k); tick();
         end
         push = 1'b0;
         for (int k = 0; k < 3; k++) begin
            e = q.pop_front();
            n_checks++; if (dout !== e) begin n_fail++; $display("FAIL wrap_dout[%0d] got %h exp %h", 3*r + k, dout, e); end
            pull = 1'b1; tick(); pull = 1'b0;
         end
      end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", empty); end
   endtask

   task automatic test_concurrent();
      push = 1'b1; din = 32'h11; tick();
      din = 32'h22; tick();
      din = 32'h33; pull = 1'b1; tick();
      push = 1'b0; pull = 1'b0;
      n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL conc_level got %0d exp 2", level); end
      n_checks++; if (dout !== 32'h22) begin n_fail++; $display("FAIL conc_dout0 got %h exp 22", dout); end
      pull = 1'b1; tick(); pull = 1'b0;
      n_checks++; if (dout !== 32'h33) begin n_fail++; $display("FAIL conc_dout1 got %h exp 33", dout); end
      for (int i = 0; i < 7; i++) begin
         push = 1'b1; din = 32'h40 + i; tick();
      end
      push = 1'b0;
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL conc_full got %b exp 1", full); end
      push = 1'b1; pull = 1'b1; din = 32'hEE; tick();
      push = 1'b0; pull = 1'b0;
      n_checks++; if (level !== 4'd7 || full !== 1'b0) begin n_fail++; $display("FAIL full_pp level %0d full %b exp 7/0", level, full); end
      for (int i = 0; i < 7; i++) begin
         n_checks++; if (dout !== 32'h40 + i) begin n_fail++; $display("FAIL full_pp_dout[%0d] got %h exp %h", i, dout, 32'h40 + i); end
         pull = 1'b1; tick(); pull = 1'b0;
      end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_pp_empty got %b exp 1", empty); end
   endtask

   task automatic test_threshold();
      logic exp_b;
      thresh = 4'd3; #1;
      for (int i = 0; i < 4; i++) begin
         exp_b = (i < 3);
         n_checks++; if (below !== exp_b) begin n_fail++; $display("FAIL below_lvl%0d got %b exp %b", i, below, exp_b); end
         if (i < 3) begin push = 1'b1; din = 32'h50 + i; tick(); push = 1'b0; end
      end
      thresh = 4'd0; #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (below !== 1'b0) begin n_fail++; $display("FAIL below_t0[%0d] got %b exp 0", i, below); end
         pull = 1'b1; tick(); pull = 1'b0;
      end
      n_checks++; if (below !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL below_t0_empty below %b empty %b exp 0/1", below, empty); end
   endtask

   task automatic test_join_toggle();
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; din = 32'h60 + i; tick();
      end
      n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL tog_pre_level got %0d exp 3", level); end
      fjoin = 1'b0; push = 1'b1; din = 32'h77; tick();
      push = 1'b0;
      n_checks++; if (level !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL tog_flush level %0d empty %b exp 0/1", level, empty); end
      tick();
      n_checks++; if (empty !== 1'b1 || dout !== 32'h0) begin n_fail++; $display("FAIL tog_nostore empty %b dout %h exp 1/0", empty, dout); end
      push = 1'b1; din = 32'h81; tick();
      din = 32'h82; tick();
      n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL burst_level got %0d exp 2", level); end
      reset = 1'b1; din = 32'h83; tick();
      reset = 1'b0; push = 1'b0;
      n_checks++; if (level !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL midrst level %0d empty %b exp 0/1", level, empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL midrst_cap0 full %b exp 0", full); end
   endtask

`ifdef FIFO_ERR_EN
   task automatic test_errors();
      for (int i = 0; i < 4; i++) begin push = 1'b1; din = 32'h90 + i; tick(); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b exp 0", overflow); end
      tick();
      push = 1'b0;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
      tick();
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_hold got %b exp 1", overflow); end
      for (int i = 0; i < 5; i++) begin pull = 1'b1; tick(); end
      pull = 1'b0;
      n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set got %b exp 1", underflow); end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL err_clr ovf %b udf %b exp 0/0", overflow, underflow); end
      for (int i = 0; i < 4; i++) begin push = 1'b1; din = 32'h98 + i; tick(); end
      err_clr = 1'b1; tick();
      err_clr = 1'b0; push = 1'b0;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_vs_clr got %b exp 1", overflow); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drain();
      test_join_capacity();
      test_concurrent();
      test_threshold();
      test_join_toggle();
`ifdef FIFO_ERR_EN
      test_errors();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
